// File: rtl/mult_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiplier controller:
// FSM state encoding and iteration count.
package mult_seq_ctrl_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ABS_A  = 3'd1;
    localparam logic [2:0] S_ABS_B  = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_NEG_LO = 3'd4;
    localparam logic [2:0] S_NEG_HI = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam int ITER_N = 32;

endpackage

// File: rtl/adder.sv
// Shared 32-bit combinational adder, no carry in or out.
// Carries are recovered by the caller where needed.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle 32x32->64 MULT/MULTU controller built around
// one shared adder: abs fix-up, 32 shift-add steps, negate.
module mult_seq_ctrl
    import mult_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [2:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             neg;
    logic             sgn;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] acc;
    logic             c_out;

    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            S_ABS_A: begin
                add_a = ~mcand;
                add_b = ONE;
            end
            S_ABS_B, S_NEG_LO: begin
                add_a = ~lo;
                add_b = ONE;
            end
            S_ITER: begin
                add_a = hi;
                add_b = mcand;
            end
            S_NEG_HI: begin
                add_a = ~hi;
                add_b = {{(WIDTH-1){1'b0}}, carry};
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    adder #(.WIDTH(WIDTH)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (sum)
    );

    // Carry out of the adder is recovered by unsigned wrap detection.
    assign acc   = lo[0] ? sum : hi;
    assign c_out = lo[0] & (sum < hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            neg   <= 1'b0;
            sgn   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand <= op_a;
                        lo    <= op_b;
                        hi    <= '0;
                        cnt   <= '0;
                        carry <= 1'b0;
                        sgn   <= is_signed;
                        neg   <= is_signed &
                                 (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        busy  <= 1'b1;
                        state <= is_signed ? S_ABS_A : S_ITER;
                    end
                end
                S_ABS_A: begin
                    if (mcand[WIDTH-1]) mcand <= sum;
                    state <= S_ABS_B;
                end
                S_ABS_B: begin
                    if (lo[WIDTH-1]) lo <= sum;
                    state <= S_ITER;
                end
                S_ITER: begin
                    {hi, lo} <= {c_out, acc, lo[WIDTH-1:1]};
                    cnt      <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        if (sgn) begin
                            state <= S_NEG_LO;
                        end else begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                S_NEG_LO: begin
                    if (neg) begin
                        lo    <= sum;
                        carry <= (lo == '0);
                    end else begin
                        carry <= 1'b0;
                    end
                    state <= S_NEG_HI;
                end
                S_NEG_HI: begin
                    if (neg) hi <= sum;
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: latency, products,
// handshake robustness and asynchronous abort.
module tb_mult_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests;
    int n_fail;

    mult_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Launch one op on the next edge, measure latency in cycles
    // from the start-sampling edge, then verify results and
    // that the controller settles in idle. With poke set,
    // spurious starts hit cycles 5, 20 and the done cycle.
    task automatic run_op(input string tag,
                          input logic sgn,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo,
                          input int exp_lat,
                          input logic poke);
        int lat;
        int busy_cnt;
        int done_cnt;
        bit seen;
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        op_a      = a;
        op_b      = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (lat < 60) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            start     = poke && (lat == 5 || lat == 20);
            is_signed = 1'b1;
            op_a      = 32'hDEAD_BEEF;
            op_b      = 32'h1234_5678;
            @(negedge clk);
            lat++;
        end
        check({tag, " done seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(busy_cnt),
              64'(exp_lat - 1));
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        start    = poke;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) done_cnt++;
            if (busy) done_cnt += 100;
        end
        check({tag, " idle after"}, 64'(done_cnt), 64'd0);
        check({tag, " hi held"}, 64'(hi), 64'(exp_hi));
        check({tag, " lo held"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int done_cnt;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        rst_n = 1'b1;

        run_op("multu 3x5", 1'b0, 32'd3, 32'd5,
               32'h0, 32'hF, 33, 1'b0);
        run_op("multu ffx ff", 1'b0, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1,
               33, 1'b0);
        run_op("mult -3x5", 1'b1, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 37, 1'b0);
        run_op("mult -7x-6", 1'b1, 32'hFFFF_FFF9,
               32'hFFFF_FFFA, 32'h0, 32'h2A, 37, 1'b0);
        run_op("mult min x min", 1'b1, 32'h8000_0000,
               32'h8000_0000, 32'h4000_0000, 32'h0,
               37, 1'b0);
        run_op("mult min x 1", 1'b1, 32'h8000_0000, 32'd1,
               32'hFFFF_FFFF, 32'h8000_0000, 37, 1'b0);
        run_op("mult 0x-5", 1'b1, 32'd0, 32'hFFFF_FFFB,
               32'h0, 32'h0, 37, 1'b0);
        run_op("multu 2x2 poke", 1'b0, 32'd2, 32'd2,
               32'h0, 32'h4, 33, 1'b1);

        // Abort a signed op at iteration 10 (cycle 13).
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b1;
        op_a      = 32'h1234_5678;
        op_b      = 32'hFFFF_FFFD;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        done_cnt = 0;
        for (int i = 1; i < 13; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("abort busy before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("abort no done", 64'(done_cnt), 64'd0);

        run_op("multu 7x9", 1'b0, 32'd7, 32'd9,
               32'h0, 32'd63, 33, 1'b0);

        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule
